// File: rtl/shift_arb_pkg.sv
// Shared definitions for the two-requester shift arbiter.
package shift_arb_pkg;

  // Result-register occupancy
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Shift direction encoding on the request ports
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Requester identifiers as reported on resp_id
  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/barrel_shifter32.sv
// Logarithmic barrel shifter: logical left or right shift, zero fill.
module barrel_shifter32
  import shift_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   i_data,
  input  logic [SHAMT_W-1:0] i_amount,
  input  logic               i_dir,
  output logic [WIDTH-1:0]   o_data
);

  logic [WIDTH-1:0] w_stage;

  // Each set bit of the amount shifts by its power of two, one stage per bit
  always_comb begin
    w_stage = i_data;
    for (int s = 0; s < SHAMT_W; s++) begin
      if (i_amount[s]) begin
        if (i_dir == DIR_RIGHT) begin
          w_stage = w_stage >> (1 << s);
        end else begin
          w_stage = w_stage << (1 << s);
        end
      end
    end
    o_data = w_stage;
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two requesters sharing one barrel shifter through a round-robin grant
// and a single-entry result register.
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_data,
  input  logic [SHAMT_W-1:0] req0_amount,
  input  logic               req0_dir,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_data,
  input  logic [SHAMT_W-1:0] req1_amount,
  input  logic               req1_dir,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [WIDTH-1:0]   resp_data
);

  state_t             r_state;
  state_t             w_next_state;
  logic               r_prio;
  logic               r_resp_id;
  logic [WIDTH-1:0]   r_resp_data;

  logic               w_free;
  logic               w_grant_id;
  logic               w_accept;
  logic [WIDTH-1:0]   w_mux_data;
  logic [SHAMT_W-1:0] w_mux_amount;
  logic               w_mux_dir;
  logic [WIDTH-1:0]   w_shifted;

  assign resp_valid = (r_state == FULL);
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;

  // The slot can take a new result if it is empty or being drained this cycle;
  // on a tie the priority pointer picks, otherwise the lone valid requester wins
  assign w_free     = !resp_valid || resp_ready;
  assign w_grant_id = (req0_valid && req1_valid) ? r_prio : req1_valid;
  assign w_accept   = (req0_valid || req1_valid) && w_free;

  // Readies are held low while reset is asserted so nothing looks accepted
  assign req0_ready = rst_n && w_free && req0_valid && (w_grant_id == REQ_ID0);
  assign req1_ready = rst_n && w_free && req1_valid && (w_grant_id == REQ_ID1);

  assign w_mux_data   = (w_grant_id == REQ_ID1) ? req1_data   : req0_data;
  assign w_mux_amount = (w_grant_id == REQ_ID1) ? req1_amount : req0_amount;
  assign w_mux_dir    = (w_grant_id == REQ_ID1) ? req1_dir    : req0_dir;

  barrel_shifter32 #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .i_data   (w_mux_data),
    .i_amount (w_mux_amount),
    .i_dir    (w_mux_dir),
    .o_data   (w_shifted)
  );

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Fill on acceptance, drain only when the consumer takes it with no refill
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      EMPTY: if (w_accept) w_next_state = FULL;
      FULL:  if (resp_ready && !w_accept) w_next_state = EMPTY;
      default: w_next_state = EMPTY;
    endcase
  end

  // Capture the shifted result and rotate priority away from the winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_data <= '0;
      r_resp_id   <= REQ_ID0;
      r_prio      <= REQ_ID0;
    end else if (w_accept) begin
      r_resp_data <= w_shifted;
      r_resp_id   <= w_grant_id;
      r_prio      <= !w_grant_id;
    end
  end

endmodule
